master_bus_requester: RTL
=========================

// Module: master_bus_requester
// PURPOSE
//  Master-side end of the serial-bus arbitration handshake; one instance sits in each master.
//  - Accepts a transfer request and a slave address from the master core.
//  - Raises RQST and shifts the slave address LSB-first on SLAVE_SEL, then waits for GRANT.
//  - Holds bus ownership until the core reports completion, then pulses TX_DONE to the arbiter.
//  - Tracks split suspension (GRANT withdrawn mid-transfer) and resumption; times out and retries.
// PARAMETERS
//  ADDR_W           2    slave address width; bits are shifted LSB-first, one per clock
//  GRANT_TIMEOUT    16   cycles in WAIT_GRANT before RQST is dropped (1..255)
//  RETRY_MAX        3    address/request attempts before req_error (1..15)
//  SUSPEND_TIMEOUT  255  max cycles in SUSPEND before abort with req_error (1..65535)
// PORTS
//  MASTER_CLK  in   1       system clock, all logic on rising edge
//  MASTER_RST  in   1       reset, asynchronous, active-high
//  req_start   in   1       core: start transfer; accepted only when req_ready=1
//  req_addr    in   ADDR_W  core: target slave address, sampled with accepted req_start
//  xfer_done   in   1       core: single-cycle pulse, data phase finished (honoured in OWN only)
//  req_ready   out  1       requester idle, can accept req_start
//  bus_owned   out  1       core may drive the bus this cycle
//  suspended   out  1       transfer paused by slave split
//  req_error   out  1       1-cycle pulse: retries exhausted or suspend timeout
//  RQST        out  1       bus request to arbiter
//  SLAVE_SEL   out  1       serial slave address to arbiter
//  GRANT       in   1       grant from arbiter
//  BUS_BUSY    in   1       arbiter: bus owned by some master
//  ARB_BUSY    in   1       arbiter: arbitration in progress
//  TX_DONE     out  1       1-cycle pulse to arbiter: transfer complete
// BEHAVIOUR
//  - All outputs registered.
//  - Reset: state=IDLE; req_ready=1; RQST, SLAVE_SEL, TX_DONE, bus_owned, suspended, req_error=0.
//    All counters and the address latch clear. Reset mid-transfer aborts silently (no TX_DONE).
//  - IDLE: req_start=1 -> latch req_addr, retry_cnt=0, req_ready<=0 -> WAIT_BUS. Otherwise stay.
//    req_start while req_ready=0 is ignored.
//  - WAIT_BUS: if BUS_BUSY=0 and ARB_BUSY=0 -> RQST<=1, SLAVE_SEL<=addr[0], bit_cnt<=1 -> ADDR.
//  - ADDR: SLAVE_SEL<=addr[bit_cnt], bit_cnt++. After bit ADDR_W-1 has been driven for one cycle:
//    SLAVE_SEL<=0, tmo_cnt<=0 -> WAIT_GRANT.
//    Each address bit is valid for exactly one cycle; bit 0 is coincident with the RQST rising edge.
//  - WAIT_GRANT: RQST held at 1.
//    - GRANT=1 -> bus_owned<=1 -> OWN.
//    - Otherwise tmo_cnt++. When tmo_cnt reaches GRANT_TIMEOUT-1: RQST<=0, retry_cnt++.
//      If retry_cnt+1 == RETRY_MAX -> req_error<=1 (one pulse), req_ready<=1 -> IDLE; else -> WAIT_BUS.
//    - GRANT wins over timeout in the same cycle.
//  - OWN: RQST held at 1.
//    - xfer_done=1 -> TX_DONE<=1, RQST<=0, bus_owned<=0 -> DONE.
//    - else GRANT=0 (split) -> RQST<=0, bus_owned<=0, suspended<=1, sus_cnt<=0 -> SUSPEND.
//    - xfer_done and GRANT=0 in the same cycle: completion wins.
//  - SUSPEND: RQST stays 0, so the arbiter may serve the other master.
//    - GRANT=1 -> RQST<=1, bus_owned<=1, suspended<=0 -> OWN. No re-addressing.
//    - sus_cnt reaches SUSPEND_TIMEOUT-1 -> suspended<=0, req_error pulse, req_ready<=1 -> IDLE.
//  - DONE: TX_DONE<=0, req_ready<=1 -> IDLE. TX_DONE is therefore exactly 1 cycle wide.
//  - GRANT rising in IDLE, WAIT_BUS or ADDR is ignored (grant belongs to the other master).
//  - Counters saturate and never wrap; all widths are sized from the parameters.
// TESTING
//  - Reset, then req_start with req_addr=2'b10, bus free -> RQST rises with SLAVE_SEL=0;
//    next cycle SLAVE_SEL=1; GRANT 3 cycles later -> bus_owned=1 the cycle after.
//  - In OWN, xfer_done pulse -> TX_DONE=1 for exactly 1 cycle with RQST=0, req_ready=1 two cycles
//    after xfer_done.
//  - BUS_BUSY=1 held 10 cycles -> RQST stays 0 throughout; release -> address sequence starts next edge.
//  - GRANT never given, RETRY_MAX=3, GRANT_TIMEOUT=16 -> three address sequences, then one
//    req_error pulse, req_ready=1.
//  - GRANT dropped for 5 cycles in OWN -> suspended=1 and RQST=0 for 5 cycles; GRANT back ->
//    bus_owned=1, no SLAVE_SEL activity.
//  - MASTER_RST asserted during ADDR and during SUSPEND -> every output at its reset value
//    immediately; no TX_DONE pulse.

Source files
------------

// File: rtl/master_bus_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : master_bus_requester_if
// Brief    : Core-side and arbiter-side handshake bundle of one bus master.
// Revision : 1.0 - initial release
// ============================================================================
interface master_bus_requester_if #(
    parameter int ADDR_W = 2
);
    // Master core side
    logic              req_start;
    logic [ADDR_W-1:0] req_addr;
    logic              xfer_done;
    logic              req_ready;
    logic              bus_owned;
    logic              suspended;
    logic              req_error;
    // Arbiter side
    logic              RQST;
    logic              SLAVE_SEL;
    logic              GRANT;
    logic              BUS_BUSY;
    logic              ARB_BUSY;
    logic              TX_DONE;

    // Requester end of the link
    modport master (
        input  req_start, req_addr, xfer_done, GRANT, BUS_BUSY, ARB_BUSY,
        output req_ready, bus_owned, suspended, req_error, RQST, SLAVE_SEL, TX_DONE
    );

    // Core/arbiter end of the link
    modport slave (
        output req_start, req_addr, xfer_done, GRANT, BUS_BUSY, ARB_BUSY,
        input  req_ready, bus_owned, suspended, req_error, RQST, SLAVE_SEL, TX_DONE
    );
endinterface
`default_nettype wire

// File: rtl/master_bus_requester.sv
`default_nettype none
// ============================================================================
// Module   : master_bus_requester
// Brief    : Master-side arbitration handshake: request, serial addressing,
//            ownership, split suspension/resumption, timeout and retry.
// Revision : 1.0 - initial release
// ============================================================================
module master_bus_requester #(
    parameter int ADDR_W          = 2,
    parameter int GRANT_TIMEOUT   = 16,
    parameter int RETRY_MAX       = 3,
    parameter int SUSPEND_TIMEOUT = 255
) (
    input  wire logic              MASTER_CLK,
    input  wire logic              MASTER_RST,
    master_bus_requester_if.master bus
);

    localparam int c_BIT_W = $clog2(ADDR_W + 1);
    localparam int c_TMO_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int c_RTY_W = $clog2(RETRY_MAX + 1);
    localparam int c_SUS_W = $clog2(SUSPEND_TIMEOUT + 1);

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(ADDR_W);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(GRANT_TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_LAST = c_RTY_W'(RETRY_MAX - 1);
    localparam logic [c_SUS_W-1:0] c_SUS_LAST = c_SUS_W'(SUSPEND_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_BUS   = 3'd1,
        S_ADDR       = 3'd2,
        S_WAIT_GRANT = 3'd3,
        S_OWN        = 3'd4,
        S_SUSPEND    = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t              r_state,     w_state_nx;
    logic [ADDR_W-1:0]   r_addr,      w_addr_nx;
    logic [ADDR_W-1:0]   r_shift,     w_shift_nx;
    logic [c_BIT_W-1:0]  r_bit_cnt,   w_bit_cnt_nx;
    logic [c_TMO_W-1:0]  r_tmo_cnt,   w_tmo_cnt_nx;
    logic [c_RTY_W-1:0]  r_retry_cnt, w_retry_cnt_nx;
    logic [c_SUS_W-1:0]  r_sus_cnt,   w_sus_cnt_nx;
    logic                r_req_ready, w_req_ready_nx;
    logic                r_bus_owned, w_bus_owned_nx;
    logic                r_suspended, w_suspended_nx;
    logic                r_req_error, w_req_error_nx;
    logic                r_rqst,      w_rqst_nx;
    logic                r_sel,       w_sel_nx;
    logic                r_tx_done,   w_tx_done_nx;

    always_ff @(posedge MASTER_CLK or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_retry_cnt <= '0;
            r_sus_cnt   <= '0;
            r_req_ready <= 1'b1;
            r_bus_owned <= 1'b0;
            r_suspended <= 1'b0;
            r_req_error <= 1'b0;
            r_rqst      <= 1'b0;
            r_sel       <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_shift     <= w_shift_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_tmo_cnt   <= w_tmo_cnt_nx;
            r_retry_cnt <= w_retry_cnt_nx;
            r_sus_cnt   <= w_sus_cnt_nx;
            r_req_ready <= w_req_ready_nx;
            r_bus_owned <= w_bus_owned_nx;
            r_suspended <= w_suspended_nx;
            r_req_error <= w_req_error_nx;
            r_rqst      <= w_rqst_nx;
            r_sel       <= w_sel_nx;
            r_tx_done   <= w_tx_done_nx;
        end
    end

    // Counters only advance below their terminal value, so they saturate.
    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_shift_nx     = r_shift;
        w_bit_cnt_nx   = r_bit_cnt;
        w_tmo_cnt_nx   = r_tmo_cnt;
        w_retry_cnt_nx = r_retry_cnt;
        w_sus_cnt_nx   = r_sus_cnt;
        w_req_ready_nx = r_req_ready;
        w_bus_owned_nx = r_bus_owned;
        w_suspended_nx = r_suspended;
        w_req_error_nx = 1'b0;
        w_rqst_nx      = r_rqst;
        w_sel_nx       = r_sel;
        w_tx_done_nx   = r_tx_done;

        unique case (r_state)
            S_IDLE: begin
                if (bus.req_start) begin
                    w_addr_nx      = bus.req_addr;
                    w_retry_cnt_nx = '0;
                    w_req_ready_nx = 1'b0;
                    w_state_nx     = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                if (!bus.BUS_BUSY && !bus.ARB_BUSY) begin
                    w_rqst_nx    = 1'b1;
                    w_sel_nx     = r_addr[0];
                    w_shift_nx   = r_addr >> 1;
                    w_bit_cnt_nx = c_BIT_W'(1);
                    w_state_nx   = S_ADDR;
                end
            end
            S_ADDR: begin
                // The shift register holds the bits still to be sent.
                if (r_bit_cnt == c_BIT_LAST) begin
                    w_sel_nx     = 1'b0;
                    w_tmo_cnt_nx = '0;
                    w_state_nx   = S_WAIT_GRANT;
                end else begin
                    w_sel_nx     = r_shift[0];
                    w_shift_nx   = r_shift >> 1;
                    w_bit_cnt_nx = r_bit_cnt + 1'b1;
                end
            end
            S_WAIT_GRANT: begin
                if (bus.GRANT) begin
                    w_bus_owned_nx = 1'b1;
                    w_state_nx     = S_OWN;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_rqst_nx = 1'b0;
                    if (r_retry_cnt == c_RTY_LAST) begin
                        w_req_error_nx = 1'b1;
                        w_req_ready_nx = 1'b1;
                        w_state_nx     = S_IDLE;
                    end else begin
                        w_retry_cnt_nx = r_retry_cnt + 1'b1;
                        w_state_nx     = S_WAIT_BUS;
                    end
                end else begin
                    w_tmo_cnt_nx = r_tmo_cnt + 1'b1;
                end
            end
            S_OWN: begin
                // Completion takes priority over a simultaneous split.
                if (bus.xfer_done) begin
                    w_tx_done_nx   = 1'b1;
                    w_rqst_nx      = 1'b0;
                    w_bus_owned_nx = 1'b0;
                    w_state_nx     = S_DONE;
                end else if (!bus.GRANT) begin
                    w_rqst_nx      = 1'b0;
                    w_bus_owned_nx = 1'b0;
                    w_suspended_nx = 1'b1;
                    w_sus_cnt_nx   = '0;
                    w_state_nx     = S_SUSPEND;
                end
            end
            S_SUSPEND: begin
                if (bus.GRANT) begin
                    w_rqst_nx      = 1'b1;
                    w_bus_owned_nx = 1'b1;
                    w_suspended_nx = 1'b0;
                    w_state_nx     = S_OWN;
                end else if (r_sus_cnt == c_SUS_LAST) begin
                    w_suspended_nx = 1'b0;
                    w_req_error_nx = 1'b1;
                    w_req_ready_nx = 1'b1;
                    w_state_nx     = S_IDLE;
                end else begin
                    w_sus_cnt_nx = r_sus_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_tx_done_nx   = 1'b0;
                w_req_ready_nx = 1'b1;
                w_state_nx     = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = r_req_ready;
    assign bus.bus_owned = r_bus_owned;
    assign bus.suspended = r_suspended;
    assign bus.req_error = r_req_error;
    assign bus.RQST      = r_rqst;
    assign bus.SLAVE_SEL = r_sel;
    assign bus.TX_DONE   = r_tx_done;

endmodule
`default_nettype wire
